// File: rtl/led_circ_sequencer.sv
// Mode sequencer for the LED circulate datapath: steps IDLE -> four circulate
// modes on key presses or auto-advance, and emits a one-cycle step strobe.
module led_circ_sequencer #(
  parameter int TICK_DIV    = 50_000_000,
  parameter int AUTO_CYCLES = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_pulse,
  input  logic       stop,
  input  logic       pause,
  input  logic       auto_en,
  output logic       step,
  output logic       rotate,
  output logic       up,
  output logic [3:0] mode_code,
  output logic [3:0] step_cnt
);

  localparam int              PW        = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRESC_TC  = PW'(TICK_DIV - 1);
  localparam logic [3:0]      AUTO_LAST = 4'(AUTO_CYCLES - 1);

  // Encoding matches the display digit so mode_code is a direct copy.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ROT_UP = 3'd1,
    ROT_DN = 3'd2,
    SHF_UP = 3'd3,
    SHF_DN = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q;
  logic          run, tc, auto_adv, clear;

  function automatic state_t advance(input state_t s);
    case (s)
      ROT_UP:  advance = ROT_DN;
      ROT_DN:  advance = SHF_UP;
      SHF_UP:  advance = SHF_DN;
      default: advance = ROT_UP;   // IDLE and SHF_DN both enter ROT_UP
    endcase
  endfunction

  assign run      = (state_q != IDLE) && !pause;
  assign tc       = run && (presc_q == PRESC_TC);
  // The visible strobe is the trigger; step_cnt has not yet counted it.
  assign auto_adv = auto_en && step && (step_cnt == AUTO_LAST);

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    if (stop) begin
      state_d = IDLE;
      clear   = 1'b1;
    end else if (key_pulse || auto_adv) begin
      state_d = advance(state_q);
      clear   = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      rotate    <= 1'b0;
      up        <= 1'b0;
      mode_code <= 4'd0;
    end else begin
      state_q   <= state_d;
      rotate    <= (state_d == ROT_UP) || (state_d == ROT_DN);
      up        <= (state_d == ROT_UP) || (state_d == SHF_UP);
      mode_code <= 4'(state_d);
    end
  end

  // A mode change (or stop) wins over a coincident terminal count: the
  // strobe is dropped and both counters restart from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q  <= '0;
      step     <= 1'b0;
      step_cnt <= 4'd0;
    end else if (clear) begin
      presc_q  <= '0;
      step     <= 1'b0;
      step_cnt <= 4'd0;
    end else begin
      step <= tc;
      if (tc)
        presc_q <= '0;
      else if (run)
        presc_q <= presc_q + PW'(1);
      if (step)
        step_cnt <= step_cnt + 4'd1;
    end
  end

endmodule

// File: tb/tb_led_circ_sequencer.sv
// Self-checking bench for led_circ_sequencer with TICK_DIV=4, AUTO_CYCLES=3:
// a mode/cycle-count model checked every cycle plus directed literal checks.
module tb_led_circ_sequencer;

  localparam int TD = 4;
  localparam int AC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       key_pulse = 1'b0;
  logic       stop = 1'b0;
  logic       pause = 1'b0;
  logic       auto_en = 1'b0;
  logic       step, rotate, up;
  logic [3:0] mode_code, step_cnt;

  int checks = 0;
  int errors = 0;

  led_circ_sequencer #(.TICK_DIV(TD), .AUTO_CYCLES(AC)) dut (
    .clk       (clk),
    .reset     (reset),
    .key_pulse (key_pulse),
    .stop      (stop),
    .pause     (pause),
    .auto_en   (auto_en),
    .step      (step),
    .rotate    (rotate),
    .up        (up),
    .mode_code (mode_code),
    .step_cnt  (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode number, unpaused cycles spent in the mode, strobes counted.
  int m_mode   = 0;
  int m_active = 0;
  int m_steps  = 0;
  bit m_step   = 0;
  bit prev_step = 0;

  always @(posedge clk) begin
    bit adv;
    if (reset) begin
      m_mode = 0; m_active = 0; m_steps = 0; m_step = 0;
    end else begin
      adv = key_pulse || (auto_en && m_step && (m_steps % 16) == AC - 1);
      if (stop || adv) begin
        m_mode   = stop ? 0 : ((m_mode == 0 || m_mode == 4) ? 1 : m_mode + 1);
        m_active = 0; m_steps = 0; m_step = 0;
      end else begin
        if (m_step) m_steps++;
        m_step = 0;
        if (m_mode != 0 && !pause) begin
          m_active++;
          m_step = (m_active % TD) == 0;
        end
      end
    end
    #1;
    check("model_step",   step,      m_step);
    check("model_rotate", rotate,    (m_mode == 1 || m_mode == 2));
    check("model_up",     up,        (m_mode == 1 || m_mode == 3));
    check("model_mode",   mode_code, m_mode[3:0]);
    check("model_cnt",    step_cnt,  4'(m_steps % 16));
    check("no_double_step", prev_step && step, 1'b0);
    prev_step = step;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_out(input string name, input logic s, input logic r, input logic u,
                            input logic [3:0] m, input logic [3:0] c);
    check({name, "_step"},   step,      s);
    check({name, "_rotate"}, rotate,    r);
    check({name, "_up"},     up,        u);
    check({name, "_mode"},   mode_code, m);
    check({name, "_cnt"},    step_cnt,  c);
  endtask

  initial begin
    tick(2);
    reset = 1'b0;
    expect_out("reset", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("idle_no_step", step, 1'b0);
    end
    check("idle_mode", mode_code, 4'd0);

    // Single key: ROT_UP, strobes at +4, +8, +12, count reads 3 afterwards.
    key_pulse = 1'b1; tick(1); key_pulse = 1'b0;
    expect_out("enter_rot_up", 1'b0, 1'b1, 1'b1, 4'd1, 4'd0);
    for (int k = 1; k <= 13; k++) begin
      tick(1);
      check("rot_up_step", step, (k % 4) == 0);
      if (k == 5)  check("cnt_after_1", step_cnt, 4'd1);
      if (k == 9)  check("cnt_after_2", step_cnt, 4'd2);
    end
    expect_out("rot_up_3_steps", 1'b0, 1'b1, 1'b1, 4'd1, 4'd3);

    // Auto-advance through all modes and the SHF_DN -> ROT_UP wrap.
    stop = 1'b1; tick(1); stop = 1'b0;
    check("stop_to_idle", mode_code, 4'd0);
    auto_en = 1'b1;
    key_pulse = 1'b1; tick(1); key_pulse = 1'b0;
    for (int k = 1; k <= 52; k++) begin
      tick(1);
      if (k == 12) expect_out("auto_trig", 1'b1, 1'b1, 1'b1, 4'd1, 4'd2);
      if (k == 13) expect_out("auto_rot_dn", 1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
      if (k == 26) check("auto_shf_up", mode_code, 4'd3);
      if (k == 39) check("auto_shf_dn", mode_code, 4'd4);
    end
    expect_out("auto_wrap", 1'b0, 1'b1, 1'b1, 4'd1, 4'd0);

    // Key coincident with the terminal count: no strobe, one advance.
    auto_en = 1'b0;
    tick(3);
    key_pulse = 1'b1; tick(1); key_pulse = 1'b0;
    expect_out("key_tc", 1'b0, 1'b1, 1'b0, 4'd2, 4'd0);
    for (int k = 1; k <= 4; k++) begin
      tick(1);
      check("key_tc_next_step", step, k == 4);
    end

    // Key coincident with the auto-advance strobe: one advance only.
    auto_en = 1'b1;
    tick(8);
    check("key_auto_strobe", step, 1'b1);
    key_pulse = 1'b1; tick(1); key_pulse = 1'b0;
    expect_out("key_auto", 1'b0, 1'b0, 1'b1, 4'd3, 4'd0);

    // Pause for 5 cycles once the prescaler has reached 2.
    auto_en = 1'b0;
    tick(2);
    pause = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick(1);
      check("paused_no_step", step, 1'b0);
    end
    pause = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      tick(1);
      check("resume_step", step, k == 2);
    end

    // Stop beats a simultaneous key in SHF_UP.
    check("pre_stop_mode", mode_code, 4'd3);
    stop = 1'b1; key_pulse = 1'b1; tick(1); stop = 1'b0; key_pulse = 1'b0;
    expect_out("stop_key", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);

    // Reset mid-mode with the prescaler at 3 drops the pending strobe.
    key_pulse = 1'b1; tick(1); key_pulse = 1'b0;
    tick(3);
    reset = 1'b1; tick(1);
    expect_out("reset_mid", 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;
    tick(6);
    check("post_reset_idle", mode_code, 4'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_circ_sequencer.md
# led_circ_sequencer

Mode sequencer for the LED circulate datapath. It takes a debounced one-cycle key pulse, steps through four circulate modes plus idle, and drives the datapath's `rotate`/`up` controls and a one-cycle `step` strobe. The strobe replaces the free-running divided clock as the datapath advance enable. `mode_code` and `step_cnt` are 4-bit hex digits for the scanned seven-segment display.

## Interface
- `TICK_DIV`, 50_000_000: `clk` cycles between `step` strobes; legal range ≥ 2; prescaler width is `$clog2(TICK_DIV)`.
- `AUTO_CYCLES`, 8: steps per mode before auto-advance; legal range 1..15.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `key_pulse`  in  1  debounced press, exactly one cycle high per press.
- `stop`  in  1  level; forces IDLE.
- `pause`  in  1  level; freezes the prescaler and suppresses `step`.
- `auto_en`  in  1  level; enables auto-advance after `AUTO_CYCLES` steps.
- `step`  out  1  one-cycle advance strobe to the datapath.
- `rotate`  out  1  datapath rotate select.
- `up`  out  1  datapath direction select.
- `mode_code`  out  4  display digit: 0 = IDLE, 1 = ROT_UP, 2 = ROT_DN, 3 = SHF_UP, 4 = SHF_DN.
- `step_cnt`  out  4  steps issued in the current mode.

## Operation
- States and outputs (`rotate`/`up`):
  - IDLE: 0/0
  - ROT_UP: 1/1
  - ROT_DN: 1/0
  - SHF_UP: 0/1
  - SHF_DN: 0/0
- All outputs are registered and are functions of the state, except `step` and `step_cnt`.
- Transitions, one per cycle, in priority order:
  1. `stop` = 1: go to IDLE.
  2. `key_pulse` = 1: advance IDLE→ROT_UP→ROT_DN→SHF_UP→SHF_DN→ROT_UP (wraps and never re-enters IDLE).
  3. Auto-advance, using the same order: taken when `auto_en` = 1, a `step` is issued this cycle, and `step_cnt` == `AUTO_CYCLES`-1.
- Any state change clears the prescaler and `step_cnt` to 0 at the same edge. `stop` while already in IDLE also clears both.
- Prescaler:
  - Counts 0..`TICK_DIV`-1 while state ≠ IDLE and `pause` = 0.
  - At the terminal count it wraps to 0 and `step` is high for that cycle (registered, so visible the following cycle).
  - In IDLE it is held at 0.
- `pause` = 1 holds the prescaler value and forces `step` = 0. Key and stop still act, and a mode change while paused still clears the prescaler.
- `step_cnt` increments on each issued `step` and wraps 15→0 when `auto_en` = 0. With `auto_en` = 1 it is cleared by the auto-advance.
- Simultaneous `key_pulse` and step terminal count: key wins, the strobe is suppressed, and the counters clear. Key and auto-advance together: advance one state only.
- The strobe that triggers auto-advance is issued with the old mode's `rotate`/`up` still valid. The new values appear on the next cycle.

## Timing
- Reset (synchronous, `reset` = 1 at an edge):
  - After that edge: state IDLE, `step` = 0, `rotate` = 0, `up` = 0, `mode_code` = 0, `step_cnt` = 0, prescaler = 0.
  - Reset overrides all inputs.
  - Reset mid-mode drops any pending strobe.
- `key_pulse` high in cycle N: `mode_code`/`rotate`/`up` change at edge N+1.
- After entering a non-IDLE mode at edge E with `pause` = 0, the first `step` is high in cycle E+`TICK_DIV`. Later strobes follow every `TICK_DIV` cycles.
- Deasserting `pause` resumes counting from the held value. Strobe spacing then equals `TICK_DIV` plus the paused cycles.
- Auto-advance: the strobe in cycle S (the `AUTO_CYCLES`-th strobe) gives the new mode at edge S+1, with `step_cnt` = 0.
- `step` is never high for two consecutive cycles.

## Test plan
All scenarios use `TICK_DIV` = 4 and `AUTO_CYCLES` = 3.
- Reset, then 10 idle cycles → `mode_code` = 0, `rotate`/`up` = 0/0, `step` never asserts.
- One `key_pulse` → next cycle `mode_code` = 1 and `rotate`/`up` = 1/1. `step` pulses 4, 8 and 12 cycles after entry; `step_cnt` reads 1, 2, 3.
- `auto_en` = 1 in ROT_UP → third `step` at cycle +12; at cycle +13 `mode_code` = 2, `rotate`/`up` = 1/0, `step_cnt` = 0. Continue until SHF_DN, which wraps to `mode_code` = 1.
- `key_pulse` coincident with the `step` terminal count → no strobe that cycle, mode advances by exactly one, next strobe arrives 4 cycles later. Same test with key coincident with an auto-advance strobe → strobe issued, mode advances by exactly one.
- `pause` held 5 cycles after the prescaler reaches 2 → no `step` while paused; strobe arrives 2 cycles after release.
- `stop` together with `key_pulse` in SHF_UP → IDLE next cycle, `mode_code` = 0. `reset` asserted mid-mode with the prescaler at 3 → no strobe, all outputs 0 next cycle.
